ray_dir_gen: RTL and testbench
==============================

// Module: ray_dir_gen
// PURPOSE
//  Per-frame ray setup stage directly downstream of the heading/angle ROM. On frame_start it
//  drives the ROM address from the player heading and waits out the 1-cycle registered ROM
//  latency. It then latches the 80-bit camera vector once per frame and streams one Q8.8
//  ray direction per screen column (camX = -1..+1) to the DDA raycaster over valid/ready.
// PARAMETERS
//  SCREEN_W  320  columns per frame
//  COL_W     9    width of column index (ceil(log2(SCREEN_W)))
//  CAM_STEP  410  camX increment per column, Q0.16 = round(2^17/SCREEN_W)
//  N_ANGLES  126  valid ROM entries; heading >= N_ANGLES maps to address 0
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  frame_start  in   1      1-cycle pulse: begin a new frame (ignored unless IDLE)
//  heading      in   7      player heading index, sampled on the frame_start edge
//  rom_addr     out  7      registered address to the angle ROM
//  rom_angle    in   80     ROM data {dirX,dirY,planeX,planeY,invDet} each signed Q8.8, [79:64]..[15:0]
//  ray_valid    out  1      ray output valid
//  ray_ready    in   1      consumer accepts ray when valid&ready
//  ray_col      out  COL_W  column index of current ray
//  ray_dir_x    out  16     signed Q8.8 dirX + planeX*camX
//  ray_dir_y    out  16     signed Q8.8 dirY + planeY*camX
//  inv_det      out  16     frame-latched invDet Q8.8 (for sprite stage), stable whole frame
//  frame_busy   out  1      high from ADDR through last ray accepted
//  frame_done   out  1      1-cycle pulse on the cycle after the last column is accepted
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr, ray_col, ray_dir_x/y, inv_det, accumulators = 0; all flags 0.
//  FSM: IDLE -(frame_start)-> ADDR -> LATCH -> SETUP -> RUN -(col SCREEN_W-1 accepted)-> IDLE.
//   IDLE:  on frame_start: rom_addr <= (heading<N_ANGLES)?heading:0; frame_busy<=1.
//   ADDR:  one wait cycle; ROM registers its output on this edge.
//   LATCH: capture rom_angle fields into frame regs (dir, plane, inv_det).
//   SETUP: stepX = planeX*CAM_STEP, stepY = planeY*CAM_STEP (signed Q8.8 x unsigned Q0.16
//          -> Q8.24, truncated to 32b); accX = (dirX-planeX)<<<16, accY = (dirY-planeY)<<<16;
//          ray_col<=0; ray_valid<=1.
//   RUN:   ray_dir_x = accX[31:16], ray_dir_y = accY[31:16] (arithmetic floor). On
//          valid&ready: if ray_col==SCREEN_W-1 -> ray_valid<=0, frame_busy<=0, frame_done<=1,
//          IDLE; else ray_col++, acc += step.
//  Latency: ray_valid rises on the 4th rising edge counting the one that samples frame_start.
//  Throughput: 1 ray/cycle with ray_ready held high; SCREEN_W+4 cycles per frame.
//  Handshake: while valid&!ready, ray_col/ray_dir_x/ray_dir_y held stable; valid never drops
//   before acceptance. Ray outputs are registered (no comb path ready->data).
//  frame_start while not IDLE: ignored (no restart, no queuing); heading changes mid-frame have
//   no effect. frame_start on the same edge as last acceptance: ignored.
//  Accumulators are 32b signed; no saturation (|ray_dir| <= |dir|+|plane| < 2.0 by ROM contents).
//  rst mid-frame: immediate return to IDLE with reset values; next frame_start works normally.
// STRUCTURE
//  Shared package fp_doom_pkg: Q8.8 width constant, angle field slice localparams (DIRX_HI..),
//   SCREEN_W/COL_W, FSM state encoding for this block.
//  Sub-module ray_dir_acc (one axis: base, plane -> step/acc/output), instantiated for X and Y;
//   FSM, column counter and handshake stay in ray_dir_gen.
// TESTING (bench instantiates the real angle ROM plus a ROM model with forced entries)
//  1 dirX=0xFF00,dirY=0,planeX=0,planeY=0x00A9, ready=1 -> col0 (0xFF00,0xFF57), col160
//    (0xFF00,0x0000), col319 (0xFF00,0x00A8); frame_done 1 cycle after col319; 324 cycles total.
//  2 frame_start @T -> rom_addr==heading after T, ray_valid first high after the 4th edge.
//  3 ray_ready toggled pseudo-randomly -> 320 rays in order, data stable during stalls, no gaps
//    or duplicates in ray_col.
//  4 heading=127 -> rom_addr=0; frame_start pulsed mid-RUN and heading changed -> ignored, rays unchanged.
//  5 rst asserted at col 100 -> next cycle ray_valid=0, frame_busy=0, outputs 0; new frame from col 0.
//  6 back-to-back frames (frame_start same cycle as frame_done) -> frame restarts, heading resampled.

Source files
------------

// File: rtl/ray_dir_gen_pkg.sv
// rtl/ray_dir_gen_pkg.sv - shared constants, angle ROM field slices and FSM encoding for ray setup
package ray_dir_gen_pkg;

    localparam int Q_W      = 16;   // signed Q8.8 word
    localparam int ADDR_W   = 7;    // angle ROM address width
    localparam int ANGLE_W  = 80;   // one ROM word: five Q8.8 fields

    localparam int SCREEN_W = 320;  // columns per frame
    localparam int COL_W    = 9;    // ceil(log2(SCREEN_W))
    localparam int CAM_STEP = 410;  // camX increment per column, Q0.16 = round(2^17/SCREEN_W)
    localparam int N_ANGLES = 126;  // populated ROM entries

    // ROM word layout {dirX, dirY, planeX, planeY, invDet}
    localparam int DIRX_HI   = 79;
    localparam int DIRX_LO   = 64;
    localparam int DIRY_HI   = 63;
    localparam int DIRY_LO   = 48;
    localparam int PLANEX_HI = 47;
    localparam int PLANEX_LO = 32;
    localparam int PLANEY_HI = 31;
    localparam int PLANEY_LO = 16;
    localparam int INVDET_HI = 15;
    localparam int INVDET_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SETUP = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    // Headings past the populated table fall back to entry 0.
    function automatic logic [ADDR_W-1:0] clamp_heading(input logic [ADDR_W-1:0] h);
        return (h < ADDR_W'(N_ANGLES)) ? h : '0;
    endfunction

endpackage

// File: rtl/ray_dir_gen_if.sv
// rtl/ray_dir_gen_if.sv - ray direction stream (valid/ready) between setup stage and DDA raycaster
// Signals: valid (ray present), ready (consumer accepts), col (column index),
//          dir_x / dir_y (signed Q8.8 ray direction).
interface ray_dir_gen_if;
    import ray_dir_gen_pkg::*;

    logic             valid;
    logic             ready;
    logic [COL_W-1:0] col;
    logic [Q_W-1:0]   dir_x;
    logic [Q_W-1:0]   dir_y;

    modport master (output valid, col, dir_x, dir_y, input ready);
    modport slave  (input valid, col, dir_x, dir_y, output ready);

endinterface

// File: rtl/ray_dir_gen_acc.sv
// rtl/ray_dir_gen_acc.sv - one axis of ray direction: frame base/plane latch, per-column step accumulator
// Ports: clk_i, rst_i (sync active-high); latch_i captures base_i/plane_i;
//        load_i computes step and seeds acc = base-plane (camX = -1); adv_i adds one step;
//        dir_o = integer+fraction part of the accumulator (Q8.8, floor).
module ray_dir_gen_acc
    import ray_dir_gen_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           latch_i,
    input  logic           load_i,
    input  logic           adv_i,
    input  logic [Q_W-1:0] base_i,
    input  logic [Q_W-1:0] plane_i,
    output logic [Q_W-1:0] dir_o
);

    logic [Q_W-1:0]     base_q;
    logic [Q_W-1:0]     plane_q;
    logic signed [31:0] step_q;
    logic signed [31:0] acc_q;

    logic signed [31:0] base_ext;
    logic signed [31:0] plane_ext;
    logic signed [31:0] step_d;
    logic signed [31:0] seed_d;

    // Q8.8 * Q0.16 lands in Q8.24; the accumulator keeps 32 bits so its top half is Q8.8.
    always_comb begin
        base_ext  = {{16{base_q[Q_W-1]}}, base_q};
        plane_ext = {{16{plane_q[Q_W-1]}}, plane_q};
        step_d    = plane_ext * CAM_STEP;
        seed_d    = (base_ext - plane_ext) <<< 16;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q  <= '0;
            plane_q <= '0;
            step_q  <= '0;
            acc_q   <= '0;
        end else begin
            if (latch_i) begin
                base_q  <= base_i;
                plane_q <= plane_i;
            end
            if (load_i) begin
                step_q <= step_d;
                acc_q  <= seed_d;
            end else if (adv_i) begin
                acc_q <= acc_q + step_q;
            end
        end
    end

    // Taking the upper half of a two's-complement value is an arithmetic floor.
    assign dir_o = acc_q[31:16];

endmodule

// File: rtl/ray_dir_gen.sv
// rtl/ray_dir_gen.sv - per-frame ray setup: angle ROM fetch, camera latch, one ray per screen column
// Ports: clk_i, rst_i (sync active-high); frame_start_i/heading_i start a frame from IDLE;
//        rom_addr_o -> angle ROM (1-cycle registered), rom_angle_i <- ROM word;
//        inv_det_o frame-latched invDet; frame_busy_o ADDR..last accept; frame_done_o 1-cycle pulse;
//        ray (master) streams col/dir_x/dir_y with valid/ready.
module ray_dir_gen
    import ray_dir_gen_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_start_i,
    input  logic [ADDR_W-1:0] heading_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [ANGLE_W-1:0] rom_angle_i,
    output logic [Q_W-1:0]    inv_det_o,
    output logic              frame_busy_o,
    output logic              frame_done_o,
    ray_dir_gen_if.master     ray
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_W - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [COL_W-1:0]  col_q;
    logic [Q_W-1:0]    inv_det_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic start, latch, load, adv, finish;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_start_i) state_d = ST_ADDR;
            ST_ADDR:  state_d = ST_LATCH;
            ST_LATCH: state_d = ST_SETUP;
            ST_SETUP: state_d = ST_RUN;
            ST_RUN:   if (ray.ready && col_q == LAST_COL) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // valid is always high in RUN, so acceptance reduces to ready.
    always_comb begin
        start  = 1'b0;
        latch  = 1'b0;
        load   = 1'b0;
        adv    = 1'b0;
        finish = 1'b0;
        case (state_q)
            ST_IDLE:  start = frame_start_i;
            ST_LATCH: latch = 1'b1;
            ST_SETUP: load  = 1'b1;
            ST_RUN: begin
                adv    = ray.ready && (col_q != LAST_COL);
                finish = ray.ready && (col_q == LAST_COL);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rom_addr_q <= '0;
            col_q      <= '0;
            inv_det_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (start) begin
                rom_addr_q <= clamp_heading(heading_i);
                busy_q     <= 1'b1;
            end
            if (latch) inv_det_q <= rom_angle_i[INVDET_HI:INVDET_LO];
            if (load) begin
                col_q   <= '0;
                valid_q <= 1'b1;
            end
            if (adv) col_q <= col_q + 1'b1;
            if (finish) begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end
        end
    end

    ray_dir_gen_acc u_acc_x (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .latch_i (latch),
        .load_i  (load),
        .adv_i   (adv),
        .base_i  (rom_angle_i[DIRX_HI:DIRX_LO]),
        .plane_i (rom_angle_i[PLANEX_HI:PLANEX_LO]),
        .dir_o   (ray.dir_x)
    );

    ray_dir_gen_acc u_acc_y (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .latch_i (latch),
        .load_i  (load),
        .adv_i   (adv),
        .base_i  (rom_angle_i[DIRY_HI:DIRY_LO]),
        .plane_i (rom_angle_i[PLANEY_HI:PLANEY_LO]),
        .dir_o   (ray.dir_y)
    );

    assign rom_addr_o   = rom_addr_q;
    assign inv_det_o    = inv_det_q;
    assign frame_busy_o = busy_q;
    assign frame_done_o = done_q;
    assign ray.valid    = valid_q;
    assign ray.col      = col_q;

endmodule

// File: tb/tb_ray_dir_gen.sv
// tb/tb_ray_dir_gen.sv - self-checking bench for ray_dir_gen with a registered angle ROM model
module tb_ray_dir_gen;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [6:0]  heading;
    logic [6:0]  rom_addr;
    logic [79:0] rom_q;
    logic [15:0] inv_det;
    logic        frame_busy;
    logic        frame_done;

    ray_dir_gen_if ray_bus ();

    ray_dir_gen dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (frame_start),
        .heading_i     (heading),
        .rom_addr_o    (rom_addr),
        .rom_angle_i   (rom_q),
        .inv_det_o     (inv_det),
        .frame_busy_o  (frame_busy),
        .frame_done_o  (frame_done),
        .ray           (ray_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Angle ROM: one-cycle registered read.
    logic [79:0] rom_mem [128];
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Ray direction straight from the camera equation: dir + plane*camX,
    // camX = -1 + col*CAM_STEP/2^16, evaluated in Q8.24 then floored to Q8.8.
    function automatic logic [15:0] model_dir(input logic [15:0] base, input logic [15:0] plane, input int col);
        longint b, p, v;
        logic [31:0] w;
        b = longint'($signed(base));
        p = longint'($signed(plane));
        v = (b - p) * 65536 + longint'(col) * p * 410;
        w = v[31:0];
        return w[31:16];
    endfunction

    // Frame-level model, advanced at each negedge for the coming posedge.
    bit          m_idle      = 1'b1;
    bit          m_after_rst = 1'b1;
    bit          m_done_exp  = 1'b0;
    int          m_age       = 0;
    int          m_col       = 0;
    logic [6:0]  m_addr      = '0;
    logic [79:0] m_ang       = '0;

    always @(negedge clk) begin
        bit vexp;
        vexp = !m_idle && (m_age >= 4);
        chk("busy",  32'(frame_busy),    32'(!m_idle));
        chk("done",  32'(frame_done),    32'(m_done_exp));
        chk("valid", 32'(ray_bus.valid), 32'(vexp));
        if (!m_idle || m_after_rst) chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        if (m_after_rst) begin
            chk("rst_col",  32'(ray_bus.col),   32'd0);
            chk("rst_dirx", 32'(ray_bus.dir_x), 32'd0);
            chk("rst_diry", 32'(ray_bus.dir_y), 32'd0);
            chk("rst_inv",  32'(inv_det),       32'd0);
        end
        if (vexp) begin
            chk("col",     32'(ray_bus.col),   32'(m_col));
            chk("dir_x",   32'(ray_bus.dir_x), 32'(model_dir(m_ang[79:64], m_ang[47:32], m_col)));
            chk("dir_y",   32'(ray_bus.dir_y), 32'(model_dir(m_ang[63:48], m_ang[31:16], m_col)));
            chk("inv_det", 32'(inv_det),       32'(m_ang[15:0]));
        end

        if (rst) begin
            m_idle      = 1'b1;
            m_after_rst = 1'b1;
            m_done_exp  = 1'b0;
            m_age       = 0;
            m_col       = 0;
            m_addr      = '0;
        end else begin
            m_after_rst = 1'b0;
            m_done_exp  = 1'b0;
            if (m_idle) begin
                if (frame_start) begin
                    m_idle = 1'b0;
                    m_age  = 1;
                    m_col  = 0;
                    m_addr = (heading < 7'd126) ? heading : 7'd0;
                    m_ang  = rom_mem[m_addr];
                end
            end else if (m_age < 4) begin
                m_age++;
            end else if (ray_bus.ready) begin
                if (m_col == 319) begin
                    m_idle     = 1'b1;
                    m_done_exp = 1'b1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit rnd, input bit lit, output int cyc);
        cyc = 1;
        while (frame_done !== 1'b1 && cyc < 4000) begin
            if (lit && ray_bus.valid === 1'b1) begin
                if (ray_bus.col == 9'd0) begin
                    chk("t1_c0_x", 32'(ray_bus.dir_x), 32'h0000FF00);
                    chk("t1_c0_y", 32'(ray_bus.dir_y), 32'h0000FF57);
                end else if (ray_bus.col == 9'd160) begin
                    chk("t1_c160_x", 32'(ray_bus.dir_x), 32'h0000FF00);
                    chk("t1_c160_y", 32'(ray_bus.dir_y), 32'h00000000);
                end else if (ray_bus.col == 9'd319) begin
                    chk("t1_c319_x", 32'(ray_bus.dir_x), 32'h0000FF00);
                    chk("t1_c319_y", 32'(ray_bus.dir_y), 32'h000000A8);
                end
            end
            ray_bus.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
        end
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        ray_bus.ready = 1'b1;
    endtask

    task automatic run_frame(input logic [6:0] hd, input bit rnd, input bit lit, output int cyc);
        heading     = hd;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_done(rnd, lit, cyc);
    endtask

    task automatic wait_col(input int target);
        int n;
        n = 0;
        while (!(ray_bus.valid === 1'b1 && ray_bus.col == 9'(target)) && n < 2000) begin
            step();
            n++;
        end
        chk("wait_col", 32'(ray_bus.valid === 1'b1 && ray_bus.col == 9'(target)), 32'd1);
    endtask

    initial begin
        int cyc;
        rst           = 1'b1;
        frame_start   = 1'b0;
        heading       = '0;
        ray_bus.ready = 1'b1;

        for (int i = 0; i < 128; i++) begin
            rom_mem[i] = {16'($urandom_range(0, 512) - 256), 16'($urandom_range(0, 512) - 256),
                          16'($urandom_range(0, 338) - 169), 16'($urandom_range(0, 338) - 169),
                          16'($urandom)};
        end
        rom_mem[5] = {16'hFF00, 16'h0000, 16'h0000, 16'h00A9, 16'h0155};

        // Pin the model against hand-computed values.
        chk("pin_c0_y",   32'(model_dir(16'h0000, 16'h00A9, 0)),   32'h0000FF57);
        chk("pin_c160_y", 32'(model_dir(16'h0000, 16'h00A9, 160)), 32'h00000000);
        chk("pin_c319_y", 32'(model_dir(16'h0000, 16'h00A9, 319)), 32'h000000A8);
        chk("pin_c319_x", 32'(model_dir(16'hFF00, 16'h0000, 319)), 32'h0000FF00);

        step(); step(); step();
        rst = 1'b0;
        step();

        // 1: fixed camera, ready held high, full frame timing
        run_frame(7'd5, 1'b0, 1'b1, cyc);
        chk("t1_cycles", 32'(cyc), 32'd324);
        step();

        // 2: ROM address and first-valid latency
        heading     = 7'd17;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t2_addr",   32'(rom_addr),      32'd17);
        chk("t2_v_e1",   32'(ray_bus.valid), 32'd0);
        step();
        chk("t2_v_e2",   32'(ray_bus.valid), 32'd0);
        step();
        chk("t2_v_e3",   32'(ray_bus.valid), 32'd0);
        step();
        chk("t2_v_e4",   32'(ray_bus.valid), 32'd1);
        wait_done(1'b0, 1'b0, cyc);
        step();

        // 3: random backpressure
        run_frame(7'd40, 1'b1, 1'b0, cyc);
        step();

        // 4: out-of-range heading, frame_start and heading change mid-run ignored
        heading     = 7'd127;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t4_addr0", 32'(rom_addr), 32'd0);
        wait_col(50);
        heading     = 7'd9;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t4_addr_hold", 32'(rom_addr), 32'd0);
        wait_done(1'b0, 1'b0, cyc);
        step();

        // 5: reset mid-frame, then a clean frame
        heading     = 7'd40;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_col(100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", 32'(ray_bus.valid), 32'd0);
        chk("t5_busy",  32'(frame_busy),    32'd0);
        chk("t5_col",   32'(ray_bus.col),   32'd0);
        chk("t5_dirx",  32'(ray_bus.dir_x), 32'd0);
        run_frame(7'd3, 1'b0, 1'b0, cyc);
        chk("t5_cycles", 32'(cyc), 32'd324);

        // 6: start on last-accept edge ignored, start during frame_done restarts
        step();
        heading     = 7'd5;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_col(319);
        heading     = 7'd9;
        frame_start = 1'b1;
        step();
        chk("t6_done", 32'(frame_done), 32'd1);
        heading = 7'd20;
        step();
        frame_start = 1'b0;
        chk("t6_addr", 32'(rom_addr),   32'd20);
        chk("t6_busy", 32'(frame_busy), 32'd1);
        wait_done(1'b0, 1'b0, cyc);
        chk("t6_cycles", 32'(cyc), 32'd324);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
